// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one combinational ALU,
// with a single registered response slot (latency 1, throughput 1/cycle).

module alu_core (
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_c,
  output logic        zero_c,
  output logic        carry_c,
  output logic        overflow_c,
  output logic        illegal_c
);
  localparam int unsigned W   = 32;
  localparam int unsigned SHW = 5;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } op_e;

  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [SHW-1:0] shamt;

  assign sum   = {1'b0, a_i} + {1'b0, b_i};
  assign diff  = {1'b0, a_i} - {1'b0, b_i};
  assign shamt = b_i[SHW-1:0];

  // SUB carry is the borrow out of the 33-bit subtraction (1 when a < b unsigned).
  always_comb begin
    result_c   = '0;
    carry_c    = 1'b0;
    overflow_c = 1'b0;
    illegal_c  = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_c   = sum[W-1:0];
        carry_c    = sum[W];
        overflow_c = (a_i[W-1] == b_i[W-1]) && (sum[W-1] != a_i[W-1]);
      end
      OP_SUB: begin
        result_c   = diff[W-1:0];
        carry_c    = diff[W];
        overflow_c = (a_i[W-1] != b_i[W-1]) && (diff[W-1] != a_i[W-1]);
      end
      OP_AND:  result_c = a_i & b_i;
      OP_OR:   result_c = a_i | b_i;
      OP_XOR:  result_c = a_i ^ b_i;
      OP_SLL:  result_c = a_i << shamt;
      OP_SRL:  result_c = a_i >> shamt;
      OP_SRA:  result_c = W'($signed(a_i) >>> shamt);
      OP_SLT:  result_c = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: result_c = {{(W-1){1'b0}}, (a_i < b_i)};
      default: illegal_c = 1'b1;
    endcase
    zero_c = !illegal_c && (result_c == '0);
  end
endmodule

module alu_arbiter #(
  parameter logic LAST_INIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_illegal
);
  localparam int unsigned W = 32;

  logic         accept_ok;
  logic         accept;
  logic         gnt_id;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         alu_carry;
  logic         alu_overflow;
  logic         alu_illegal;

  logic         rsp_valid_q,    rsp_valid_d;
  logic         rsp_id_q,       rsp_id_d;
  logic [W-1:0] rsp_result_q,   rsp_result_d;
  logic         rsp_zero_q,     rsp_zero_d;
  logic         rsp_carry_q,    rsp_carry_d;
  logic         rsp_overflow_q, rsp_overflow_d;
  logic         rsp_illegal_q,  rsp_illegal_d;
  logic         last_q,         last_d;

  // Grant: the sole valid requester, or under contention the one not granted last.
  assign accept_ok  = !rsp_valid_q || rsp_ready;
  assign gnt_id     = (req0_valid && req1_valid) ? !last_q : req1_valid;
  assign accept     = (req0_valid || req1_valid) && accept_ok && !rst;
  assign req0_ready = accept && !gnt_id;
  assign req1_ready = accept && gnt_id;

  assign alu_a  = gnt_id ? req1_a  : req0_a;
  assign alu_b  = gnt_id ? req1_b  : req0_b;
  assign alu_op = gnt_id ? req1_op : req0_op;

  alu_core u_alu (
    .op_i       (alu_op),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .result_c   (alu_result),
    .zero_c     (alu_zero),
    .carry_c    (alu_carry),
    .overflow_c (alu_overflow),
    .illegal_c  (alu_illegal)
  );

  always_comb begin
    rsp_valid_d    = rsp_valid_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_illegal_d  = rsp_illegal_q;
    last_d         = last_q;
    if (accept) begin
      rsp_valid_d    = 1'b1;
      rsp_id_d       = gnt_id;
      rsp_result_d   = alu_result;
      rsp_zero_d     = alu_zero;
      rsp_carry_d    = alu_carry;
      rsp_overflow_d = alu_overflow;
      rsp_illegal_d  = alu_illegal;
      last_d         = gnt_id;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_carry_q    <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
      last_q         <= LAST_INIT;
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_illegal_q  <= rsp_illegal_d;
      last_q         <= last_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_overflow = rsp_overflow_q;
  assign rsp_illegal  = rsp_illegal_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: opcode vector table, hand-written handshake/reset
// sequences, and randomized traffic against a behavioural model.

module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_carry, rsp_overflow, rsp_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.LAST_INIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        carry;
    logic        ovf;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  logic [37:0] dut_bus;
  assign dut_bus = {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_illegal};

  function automatic logic [37:0] pk(input logic v, input logic id, input exp_t e);
    return {v, id, e.result, e.zero, e.carry, e.ovf, e.illegal};
  endfunction

  // Reference ALU from arithmetic definitions; SUB carry means borrow (a < b unsigned).
  function automatic exp_t ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint sa, sb, s;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    case (op)
      4'd0: begin
        r.result = a + b;
        r.carry  = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        s        = sa + sb;
        r.ovf    = s != longint'($signed(r.result));
      end
      4'd1: begin
        r.result = a - b;
        r.carry  = a < b;
        s        = sa - sb;
        r.ovf    = s != longint'($signed(r.result));
      end
      4'd2: r.result = a & b;
      4'd3: r.result = a | b;
      4'd4: r.result = a ^ b;
      4'd5: r.result = a << b[4:0];
      4'd6: r.result = a >> b[4:0];
      4'd7: r.result = $unsigned($signed(a) >>> b[4:0]);
      4'd8: r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r.result = (a < b) ? 32'd1 : 32'd0;
      default: r.illegal = 1'b1;
    endcase
    if (!r.illegal) r.zero = (r.result == 32'd0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  vec_t        vecs[15];
  exp_t        held;
  logic [37:0] held_bus;
  logic        p_v[2];
  logic [31:0] p_a[2], p_b[2];
  logic [3:0]  p_op[2];
  logic        m_valid, m_id, m_last, ok, any, g;
  exp_t        m_rsp;
  logic [1:0]  exp_rdy;

  initial begin
    vecs[0]  = '{4'h0, 32'hFFFF_FFFF, 32'h1,         '{32'h0000_0000, 1, 1, 0, 0}};
    vecs[1]  = '{4'h1, 32'h8000_0000, 32'h1,         '{32'h7FFF_FFFF, 0, 0, 1, 0}};
    vecs[2]  = '{4'h0, 32'h7FFF_FFFF, 32'h1,         '{32'h8000_0000, 0, 0, 1, 0}};
    vecs[3]  = '{4'h1, 32'h5,         32'h5,         '{32'h0000_0000, 1, 0, 0, 0}};
    vecs[4]  = '{4'h1, 32'h3,         32'h5,         '{32'hFFFF_FFFE, 0, 1, 0, 0}};
    vecs[5]  = '{4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, '{32'h00F0_00F0, 0, 0, 0, 0}};
    vecs[6]  = '{4'h3, 32'h0F0F_0000, 32'h0000_00F0, '{32'h0F0F_00F0, 0, 0, 0, 0}};
    vecs[7]  = '{4'h4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, '{32'h0000_0000, 1, 0, 0, 0}};
    vecs[8]  = '{4'h5, 32'h1,         32'h3F,        '{32'h8000_0000, 0, 0, 0, 0}};
    vecs[9]  = '{4'h6, 32'h8000_0000, 32'h4,         '{32'h0800_0000, 0, 0, 0, 0}};
    vecs[10] = '{4'h7, 32'h8000_0000, 32'h4,         '{32'hF800_0000, 0, 0, 0, 0}};
    vecs[11] = '{4'h8, 32'hFFFF_FFFF, 32'h1,         '{32'h0000_0001, 0, 0, 0, 0}};
    vecs[12] = '{4'h9, 32'hFFFF_FFFF, 32'h1,         '{32'h0000_0000, 1, 0, 0, 0}};
    vecs[13] = '{4'hC, 32'h5,         32'h3,         '{32'h0000_0000, 0, 0, 0, 1}};
    vecs[14] = '{4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{32'h0000_0000, 0, 0, 0, 1}};

    // Reset state, with both requesters valid while rst is high.
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    next_cycle();
    #1;
    check("rst_ready", 64'({req1_ready, req0_ready}), 64'(2'b00));
    check("rst_rsp", 64'(dut_bus), 64'(38'd0));
    rst = 1'b0;
    idle_inputs();
    next_cycle();

    // Opcode table through requester 0, back-to-back with rsp_ready=1.
    for (int i = 0; i < 15; i++) begin
      req0_valid = 1'b1; req0_op = vecs[i].op; req0_a = vecs[i].a; req0_b = vecs[i].b;
      req1_valid = 1'b0; rsp_ready = 1'b1;
      #1;
      check("tbl_ready", 64'({req1_ready, req0_ready}), 64'(2'b01));
      next_cycle();
      req0_valid = 1'b0;
      #1;
      check($sformatf("tbl_rsp[%0d]", i), 64'(dut_bus), 64'(pk(1'b1, 1'b0, vecs[i].e)));
    end
    next_cycle();
    #1;
    check("drain_valid", 64'(rsp_valid), 64'(1'b0));

    // Contention right after reset: grants 0,1,0,1 and continuous responses.
    do_reset();
    req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd10; req0_b = 32'd20;
    req1_valid = 1'b1; req1_op = 4'h4; req1_a = 32'h00FF; req1_b = 32'h0F0F;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 64'({req1_ready, req0_ready}), 64'((k % 2 == 0) ? 2'b01 : 2'b10));
      next_cycle();
      #1;
      if (k % 2 == 0)
        check("rr_rsp", 64'(dut_bus), 64'(pk(1'b1, 1'b0, ref_alu(4'h0, 32'd10, 32'd20))));
      else
        check("rr_rsp", 64'(dut_bus), 64'(pk(1'b1, 1'b1, ref_alu(4'h4, 32'h00FF, 32'h0F0F))));
    end

    // Backpressure: response stalls, req1 held off, then accepted.
    do_reset();
    req0_valid = 1'b1; req0_op = 4'h2; req0_a = 32'h1234_5678; req0_b = 32'h0000_FFFF;
    rsp_ready = 1'b0;
    next_cycle();
    req0_valid = 1'b0;
    held_bus = pk(1'b1, 1'b0, ref_alu(4'h2, 32'h1234_5678, 32'h0000_FFFF));
    req1_valid = 1'b1; req1_op = 4'h7; req1_a = 32'h8000_0000; req1_b = 32'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 64'({req1_ready, req0_ready}), 64'(2'b00));
      check("bp_rsp_hold", 64'(dut_bus), 64'(held_bus));
      next_cycle();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_accept", 64'({req1_ready, req0_ready}), 64'(2'b10));
    next_cycle();
    req1_valid = 1'b0;
    #1;
    held = '{32'hF800_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    check("bp_rsp_new", 64'(dut_bus), 64'(pk(1'b1, 1'b1, held)));

    // Reset with a pending response and both requesters valid.
    do_reset();
    req0_valid = 1'b1; req0_op = 4'h0; req0_a = 32'd1; req0_b = 32'd2;
    rsp_ready = 1'b0;
    next_cycle();
    req1_valid = 1'b1; req1_op = 4'h1; req1_a = 32'd9; req1_b = 32'd3;
    #1;
    check("prst_pending", 64'(rsp_valid), 64'(1'b1));
    rst = 1'b1;
    #1;
    check("inrst_ready", 64'({req1_ready, req0_ready}), 64'(2'b00));
    next_cycle();
    #1;
    check("inrst_ready2", 64'({req1_ready, req0_ready}), 64'(2'b00));
    check("inrst_valid", 64'(rsp_valid), 64'(1'b0));
    rst = 1'b0;
    #1;
    check("postrst_valid", 64'(rsp_valid), 64'(1'b0));
    rsp_ready = 1'b1;
    #1;
    check("postrst_grant", 64'({req1_ready, req0_ready}), 64'(2'b01));
    next_cycle();

    // Randomized traffic against the behavioural model.
    do_reset();
    m_valid = 1'b0; m_id = 1'b0; m_last = 1'b1; m_rsp = '0;
    for (int r = 0; r < 2; r++) begin
      p_v[r] = 1'b0; p_a[r] = '0; p_b[r] = '0; p_op[r] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_v[r] && $urandom_range(0, 99) < 60) begin
          p_v[r]  = 1'b1;
          p_op[r] = 4'($urandom_range(0, 15));
          p_a[r]  = rand_val();
          p_b[r]  = rand_val();
        end
      end
      rsp_ready  = ($urandom_range(0, 99) < 70);
      req0_valid = p_v[0]; req0_a = p_a[0]; req0_b = p_b[0]; req0_op = p_op[0];
      req1_valid = p_v[1]; req1_a = p_a[1]; req1_b = p_b[1]; req1_op = p_op[1];
      #1;
      ok      = !m_valid || rsp_ready;
      any     = ok && (p_v[0] || p_v[1]);
      g       = (p_v[0] && p_v[1]) ? !m_last : p_v[1];
      exp_rdy = any ? (g ? 2'b10 : 2'b01) : 2'b00;
      check("rnd_ready", 64'({req1_ready, req0_ready}), 64'(exp_rdy));
      if (m_valid)
        check("rnd_rsp", 64'(dut_bus), 64'(pk(1'b1, m_id, m_rsp)));
      else
        check("rnd_valid", 64'(rsp_valid), 64'(1'b0));
      @(posedge clk);
      if (any) begin
        m_rsp   = ref_alu(p_op[g], p_a[g], p_b[g]);
        m_id    = g;
        m_valid = 1'b1;
        m_last  = g;
        p_v[g]  = 1'b0;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
